// File: rtl/sub_arbiter.sv
// Two-requester round-robin arbiter in front of one shared |a-b| subtractor.
// Optional SUB_ARBITER_STATS_EN builds an 8-bit completed-operation counter.
module sub_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [N-1:0] difference,
    output logic         flagN,
    output logic         flagC,
    output logic         flagZ,
    output logic         busy,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e       state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_q, last_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [N-1:0] diff_q, diff_d;
    logic         flag_n_q, flag_n_d, flag_c_q, flag_c_d, flag_z_q, flag_z_d;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        flag_n_d = flag_n_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // Contention goes to whoever was not served last; a lone request always wins.
                    owner_d = (req0 && req1) ? ~last_q : req1;
                    a_d     = owner_d ? a1 : a0;
                    b_d     = owner_d ? b1 : b0;
                    state_d = StExec;
                end
            end
            StExec: begin
                diff_d   = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
                flag_n_d = (a_q < b_q);
                flag_c_d = (a_q >= b_q);
                flag_z_d = (a_q == b_q);
                state_d  = StDone;
            end
            StDone: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            flag_n_q <= flag_n_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

`ifdef SUB_ARBITER_STATS_EN
    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else if (state_q == StDone) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign op_count = count_q;
`else
    assign op_count = 8'd0;
`endif

    assign busy       = (state_q != StIdle);
    assign gnt0       = busy && !owner_q;
    assign gnt1       = busy && owner_q;
    assign done0      = (state_q == StDone) && !owner_q;
    assign done1      = (state_q == StDone) && owner_q;
    assign difference = diff_q;
    assign flagN      = flag_n_q;
    assign flagC      = flag_c_q;
    assign flagZ      = flag_z_q;

endmodule
